evm_result_reader: RTL

- Consumer end of the voting machine's result interface.
- Watches voting_over. When it rises, waits for the machine's result registers (rcnt1..rcnt3) to settle, then captures them.
- Computes the winner or a tie, and streams a fixed 18-byte result frame over a valid/ready byte interface toward the display/UART path.
- Publishes a completion flag that stays high until the session is closed.

---
 rtl/evm_result_reader_if.sv | 10 +
 rtl/evm_result_reader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/evm_result_reader_if.sv
// Byte-stream channel from the result reader to the display/UART path.
// out_valid/out_ready follow strict valid/ready: a byte moves on any clock where both are high.
interface evm_result_reader_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/evm_result_reader.sv
// Captures the voting machine's final counts once voting_over has settled,
// decides winner/tie and streams an 18-byte result frame with an XOR checksum.
module evm_result_reader #(
    parameter int         CNT_W         = 32,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] HEADER        = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       voting_over,
    input  logic [CNT_W-1:0]           rcnt1,
    input  logic [CNT_W-1:0]           rcnt2,
    input  logic [CNT_W-1:0]           rcnt3,
    evm_result_reader_if.master        out_if,
    output logic [1:0]                 winner,
    output logic                       tie,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CAPTURE, S_SEND, S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] LAST_IDX    = 5'd17;

    state_t           state, state_n;
    logic             vo_q, rise, xfer;
    logic [3:0]       settle_cnt;
    logic [4:0]       idx;
    logic [7:0]       chk, data_q, next_byte;
    logic [CNT_W-1:0] cap1, cap2, cap3, mx;
    logic [1:0]       n_max, win_c;
    logic             tie_c;

    assign rise = voting_over && !vo_q;
    assign xfer = (state == S_SEND) && out_if.out_ready;

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = (state == S_SEND);
    assign busy      = (state == S_SETTLE) || (state == S_CAPTURE) || (state == S_SEND);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (rise) state_n = S_SETTLE;
            S_SETTLE:  begin
                if (!voting_over)                  state_n = S_IDLE;
                else if (settle_cnt == SETTLE_LAST) state_n = S_CAPTURE;
            end
            S_CAPTURE: state_n = S_SEND;
            S_SEND:    if (xfer && idx == LAST_IDX) state_n = S_DONE;
            S_DONE:    if (!voting_over) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Winner decision on the live counts; only registered during CAPTURE.
    always_comb begin
        mx = rcnt1;
        if (rcnt2 > mx) mx = rcnt2;
        if (rcnt3 > mx) mx = rcnt3;
        n_max = {1'b0, rcnt1 == mx} + {1'b0, rcnt2 == mx} + {1'b0, rcnt3 == mx};
        win_c = 2'd0;
        tie_c = 1'b0;
        if (mx != '0) begin
            if (n_max == 2'd1) win_c = (rcnt1 == mx) ? 2'd1 : (rcnt2 == mx) ? 2'd2 : 2'd3;
            else               tie_c = 1'b1;
        end
    end

    // Byte that follows the one currently on out_data (index idx+1).
    always_comb begin
        next_byte = 8'h00;
        case (idx)
            5'd0:    next_byte = 8'h01;
            5'd1:    next_byte = cap1[31:24];
            5'd2:    next_byte = cap1[23:16];
            5'd3:    next_byte = cap1[15:8];
            5'd4:    next_byte = cap1[7:0];
            5'd5:    next_byte = 8'h02;
            5'd6:    next_byte = cap2[31:24];
            5'd7:    next_byte = cap2[23:16];
            5'd8:    next_byte = cap2[15:8];
            5'd9:    next_byte = cap2[7:0];
            5'd10:   next_byte = 8'h03;
            5'd11:   next_byte = cap3[31:24];
            5'd12:   next_byte = cap3[23:16];
            5'd13:   next_byte = cap3[15:8];
            5'd14:   next_byte = cap3[7:0];
            5'd15:   next_byte = {6'b0, winner};
            5'd16:   next_byte = chk ^ data_q;
            default: next_byte = 8'h00;
        endcase
    end

    // vo_q tracks voting_over through reset so a level already high at release is no rise.
    always_ff @(posedge clk) begin
        vo_q <= voting_over;
        if (rst) begin
            settle_cnt <= 4'd0;
            idx        <= 5'd0;
            chk        <= 8'h00;
            data_q     <= 8'h00;
            cap1       <= '0;
            cap2       <= '0;
            cap3       <= '0;
            winner     <= 2'd0;
            tie        <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   settle_cnt <= 4'd0;
                S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
                S_CAPTURE: begin
                    cap1   <= rcnt1;
                    cap2   <= rcnt2;
                    cap3   <= rcnt3;
                    winner <= win_c;
                    tie    <= tie_c;
                    idx    <= 5'd0;
                    chk    <= 8'h00;
                    data_q <= HEADER;
                end
                S_SEND: if (xfer) begin
                    chk    <= chk ^ data_q;
                    idx    <= idx + 5'd1;
                    data_q <= next_byte;
                end
                default: ;
            endcase
        end
    end
endmodule
